// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and FSM state encoding for the TX and RX blocks
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  localparam int DEFAULT_CLK_DIV = 10416;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and an occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem_q[rd_q];
  assign count = count_q;
  // storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter sending queued words back-to-back
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int DATA_BITS = 8,
  parameter int PARITY = PARITY_NONE,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head;
  logic par_q, par_d, stop_q, stop_d, txd_q, txd_d;
  logic pop, full, empty, tick;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(tx_valid & tx_ready),
    .pop(pop),
    .din(tx_data),
    .dout(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  assign tx_ready = ~full;
  assign tick = (state_q != S_IDLE) && (cnt_q == CW'(CLK_DIV - 1));
  assign busy = (state_q != S_IDLE) | ~empty;
  assign txd = txd_q;
  // frame sequencing; a pop from IDLE or from the end of STOP restarts the frame
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    stop_d = stop_q;
    pop = 1'b0;
    unique case (state_q)
      S_IDLE: pop = ~empty;
      S_START: if (tick) state_d = S_DATA;
      S_DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != PARITY_NONE) ? S_PAR : S_STOP;
      end
      S_PAR: if (tick) state_d = S_STOP;
      S_STOP: if (tick) begin
        if (STOP_BITS == 2 && !stop_q) stop_d = 1'b1;
        else begin
          pop = ~empty;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d = S_START;
      shift_d = head;
      bit_d = '0;
      stop_d = 1'b0;
      par_d = (PARITY == PARITY_EVEN) ? ^head : ~^head;
    end
    cnt_d = (pop || tick || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
    txd_d = (state_q == S_START) ? 1'b0 : (state_q == S_DATA) ? shift_q[0] : (state_q == S_PAR) ? par_q : 1'b1;
  end
  // state registers; txd follows the state one clock later so every bit is a full period
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      stop_q <= 1'b0;
      txd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      stop_q <= stop_d;
      txd_q <= txd_d;
    end
  end
endmodule
